pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Pipeline hazard and control unit for the 5-stage RV32 pipeline. It consumes the four pipeline buffer register structs (IF/ID, ID/EX, EX/MEM, MEM/WB) that the stages write, and drives:
- operand forwarding selects;
- per-register write enables, stall, bubble and flush controls;
- a data-memory wait state machine with timeout error detection.

It sits beside the datapath and is the sole reader-side arbiter of pipeline register state.

## Interface
- MEM_TIMEOUT, 16: max cycles waiting for dmem_ready before declaring an error (≥2)
- CNT_W, 32: width of performance counters
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ifid  in  if_id_reg  current IF/ID register contents
- idex  in  id_ex_reg  current ID/EX register contents
- exmem  in  ex_mem_reg  current EX/MEM register contents
- memwb  in  mem_wb_reg  current MEM/WB register contents
- br_taken  in  1  branch condition resolved true in EX (qualified by idex.Branch)
- dmem_ready  in  1  data memory completes access this cycle
- fwd_a  out  2  rs1 operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
- fwd_b  out  2  rs2 operand select, same encoding
- pc_write, ifid_write, idex_write, exmem_write  out  1 each  register load enables
- ifid_flush, idex_bubble, memwb_bubble  out  1 each  load zero/NOP struct instead of stage output
- mem_err  out  1  sticky memory timeout error
- stall_cycles, flush_count  out  CNT_W each  perf counters (only with HAZARD_PERF_CNT_EN)

## Operation
- Forwarding (combinational), rs1 and rs2 evaluated independently; EX/MEM wins over MEM/WB:
  - select 10 if exmem.RegWrite && exmem.rd≠0 && exmem.rd==idex.RS_x;
  - else 01 if memwb.RegWrite && memwb.rd≠0 && memwb.rd==idex.RS_x;
  - else 00.
- Source usage, decoded from ifid.Curr_Instr[6:0]:
  - rs1 used unless the opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111;
  - rs2 used only for opcodes 0110011, 0100011, 1100011.
- Load-use: idex.MemRead && idex.rd≠0 && idex.rd equals a used source (Curr_Instr[19:15] / [24:20]). Response: pc_write=0, ifid_write=0, idex_bubble=1.
- Redirect: (idex.Branch && br_taken) || idex.JalSel || idex.JalrSel. Response: ifid_flush=1, idex_bubble=1; pc_write stays 1 so the target loads.
- Memory wait: (exmem.MemRead || exmem.MemWrite) && !dmem_ready. Response:
  - pc_write, ifid_write, idex_write, exmem_write all 0;
  - memwb_bubble=1.
- Priority: memory wait > redirect > load-use. A redirect held during a freeze is re-evaluated after release.
- FSM states, encoded as hz_state_e:
  - RUN: normal operation. If a memory wait is detected, go to MEM_WAIT with wait_cnt=1.
  - MEM_WAIT: freeze outputs asserted. On dmem_ready, go to RUN. If wait_cnt==MEM_TIMEOUT-1 and still not ready, go to MEM_ERR. Otherwise increment wait_cnt.
  - MEM_ERR: full freeze, mem_err=1. Only rst_n exits this state.
- Default outputs: writes 1, flush/bubble 0, fwd 00.

## Timing
- fwd_*, write enables, flush and bubble are combinational from inputs plus state. Zero latency: they are valid in the same cycle the hazard appears.
- Load-use stall lasts exactly 1 cycle: the next cycle idex holds a bubble, so no re-detection.
- Redirect flush lasts exactly 1 cycle.
- mem_err rises on the clock edge where the FSM enters MEM_ERR, which is MEM_TIMEOUT cycles after the wait began.
- While rst_n is low:
  - state=RUN, wait_cnt=0, mem_err=0, counters=0;
  - writes=1, flush/bubble=0, fwd=00.
- Reset asserted mid-wait aborts the wait immediately and asynchronously.
- dmem_ready in the first wait cycle: no freeze occurs and the FSM stays in RUN.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with pc_write=0;
  - flush_count increments on every cycle with ifid_flush=1;
  - both wrap modulo 2^CNT_W.
- Undefined: both ports and their counters are absent.

## Structure
- Add to Pipe_Buf_Reg_PKG:
  - fwd_sel_e (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10);
  - hz_state_e (RUN, MEM_WAIT, MEM_ERR);
  - opcode localparams OP_R, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL.
- Sub-module pipe_fwd_sel computes one forwarding select. It is instantiated twice, for RS_One and RS_Two.

## Test plan
- Forwarding priority: exmem.rd=5 RegWrite, memwb.rd=5 RegWrite, idex.RS_One=5 -> fwd_a=10. Same setup with exmem.rd=0 -> fwd_a=01.
- Load-use: idex lw x7 (MemRead, rd=7), ifid add x1,x7,x2 -> pc_write=0, ifid_write=0, idex_bubble=1 for one cycle. Same with ifid lui x7 -> no stall.
- Jump: idex.JalSel=1 -> ifid_flush=1, idex_bubble=1, pc_write=1 for one cycle. Add a simultaneous load-use -> flush only.
- Memory wait: exmem MemRead, dmem_ready low 3 cycles then high -> all four write enables 0 and memwb_bubble=1 for 3 cycles, RUN on the 4th.
- Timeout: dmem_ready held low with MEM_TIMEOUT=4 -> mem_err=1 after 4 cycles and stays frozen. Pulse rst_n low -> mem_err=0, state RUN.
- Counters (with HAZARD_PERF_CNT_EN): one load-use stall plus one jal -> stall_cycles=1, flush_count=1.

Source files
------------

// File: rtl/Pipe_Buf_Reg_PKG.sv
// Pipeline buffer register payloads and hazard-unit types for the 5-stage RV32 core.
package Pipe_Buf_Reg_PKG;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 7;

    typedef struct packed {
        logic [XLEN-1:0] Curr_Pc;
        logic [XLEN-1:0] Curr_Instr;
    } if_id_reg;

    typedef struct packed {
        logic [XLEN-1:0]  Curr_Pc;
        logic [REG_W-1:0] RS_One;
        logic [REG_W-1:0] RS_Two;
        logic [REG_W-1:0] rd;
        logic             MemRead;
        logic             MemWrite;
        logic             RegWrite;
        logic             Branch;
        logic             JalSel;
        logic             JalrSel;
    } id_ex_reg;

    typedef struct packed {
        logic [XLEN-1:0]  Alu_Result;
        logic [XLEN-1:0]  Store_Data;
        logic [REG_W-1:0] rd;
        logic             MemRead;
        logic             MemWrite;
        logic             RegWrite;
    } ex_mem_reg;

    typedef struct packed {
        logic [XLEN-1:0]  Wb_Data;
        logic [REG_W-1:0] rd;
        logic             RegWrite;
    } mem_wb_reg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        MEM_ERR  = 2'b10
    } hz_state_e;

    localparam logic [OPC_W-1:0] OP_R     = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_S     = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_B     = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LUI   = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL   = 7'b1101111;

    function automatic logic rs1_used(input logic [OPC_W-1:0] op);
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    function automatic logic rs2_used(input logic [OPC_W-1:0] op);
        return (op == OP_R) || (op == OP_S) || (op == OP_B);
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Single-operand forwarding select; the younger EX/MEM producer wins over MEM/WB.
module pipe_fwd_sel
    import Pipe_Buf_Reg_PKG::*;
(
    input  logic [REG_W-1:0] rs_i,
    input  logic             exmem_we_i,
    input  logic [REG_W-1:0] exmem_rd_i,
    input  logic             memwb_we_i,
    input  logic [REG_W-1:0] memwb_rd_i,
    output fwd_sel_e         sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i)) begin
            sel_o = FWD_MEM;
        end else if (memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/control unit: forwarding, load-use stall, redirect flush, dmem wait/timeout FSM.
// Optional perf counters (stall_cycles, flush_count) built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_unit
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  if_id_reg         ifid,
    input  id_ex_reg         idex,
    input  ex_mem_reg        exmem,
    input  mem_wb_reg        memwb,
    input  logic             br_taken,
    input  logic             dmem_ready,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic             mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    hz_state_e          state_q, state_d;
    logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_err_q;
    fwd_sel_e           fwd_a_sel, fwd_b_sel;
    logic [OPC_W-1:0]   opcode_c;
    logic               load_use_c, redirect_c, mem_wait_c, freeze_c;
    logic               unused_ok_c;

    pipe_fwd_sel u_fwd_a (
        .rs_i       (idex.RS_One),
        .exmem_we_i (exmem.RegWrite),
        .exmem_rd_i (exmem.rd),
        .memwb_we_i (memwb.RegWrite),
        .memwb_rd_i (memwb.rd),
        .sel_o      (fwd_a_sel)
    );

    pipe_fwd_sel u_fwd_b (
        .rs_i       (idex.RS_Two),
        .exmem_we_i (exmem.RegWrite),
        .exmem_rd_i (exmem.rd),
        .memwb_we_i (memwb.RegWrite),
        .memwb_rd_i (memwb.rd),
        .sel_o      (fwd_b_sel)
    );

    // Controls are forced to their idle values while reset is held
    assign fwd_a = rst_n ? fwd_a_sel : FWD_RF;
    assign fwd_b = rst_n ? fwd_b_sel : FWD_RF;

    assign opcode_c   = ifid.Curr_Instr[OPC_W-1:0];
    assign load_use_c = idex.MemRead && (idex.rd != '0) &&
                        ((rs1_used(opcode_c) && (ifid.Curr_Instr[19:15] == idex.rd)) ||
                         (rs2_used(opcode_c) && (ifid.Curr_Instr[24:20] == idex.rd)));
    assign redirect_c = (idex.Branch && br_taken) || idex.JalSel || idex.JalrSel;
    assign mem_wait_c = (exmem.MemRead || exmem.MemWrite) && !dmem_ready;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        freeze_c     = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_wait_c) begin
                    freeze_c   = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    freeze_c = 1'b1;
                    if (wait_cnt_q == WCNT_LAST) begin
                        state_d = MEM_ERR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                    end
                end
            end
            MEM_ERR: freeze_c = 1'b1;
            default: state_d = RUN;
        endcase

        // Priority: memory freeze, then redirect, then load-use
        if (!rst_n) begin
            freeze_c = 1'b0;
        end else if (freeze_c) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (redirect_c) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use_c) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= (state_d == MEM_ERR);
        end
    end

    assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (ifid_flush) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`endif

    // Payload fields not consumed by the hazard logic
    assign unused_ok_c = ^{ifid, idex, exmem, memwb, 1'(CNT_W)};

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed self-checking bench for pipe_hazard_unit (MEM_TIMEOUT=4).
`timescale 1ns/1ps
module tb_pipe_hazard_unit;
    import Pipe_Buf_Reg_PKG::*;

    localparam logic [6:0] NORM   = 7'b1111000;
    localparam logic [6:0] STALL  = 7'b0011010;
    localparam logic [6:0] FLUSH  = 7'b1111110;
    localparam logic [6:0] FREEZE = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst_n;
    if_id_reg   ifid;
    id_ex_reg   idex;
    ex_mem_reg  exmem;
    mem_wb_reg  memwb;
    logic       br_taken, dmem_ready;
    logic [1:0] fwd_a, fwd_b;
    logic       pc_write, ifid_write, idex_write, exmem_write;
    logic       ifid_flush, idex_bubble, memwb_bubble, mem_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ifid         (ifid),
        .idex         (idex),
        .exmem        (exmem),
        .memwb        (memwb),
        .br_taken     (br_taken),
        .dmem_ready   (dmem_ready),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_write   (idex_write),
        .exmem_write  (exmem_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .memwb_bubble (memwb_bubble),
        .mem_err      (mem_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    function automatic logic [6:0] ctl();
        return {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble, memwb_bubble};
    endfunction

    task automatic clr();
        ifid = '0; idex = '0; exmem = '0; memwb = '0;
        br_taken = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr();
        exmem.RegWrite = 1'b1; exmem.rd = 5'd5; idex.RS_One = 5'd5; idex.RS_Two = 5'd5;
        idex.JalSel = 1'b1; exmem.MemRead = 1'b1; dmem_ready = 1'b0;
        #7;
        total++;
        if (ctl() !== NORM || fwd_a !== 2'b00 || fwd_b !== 2'b00 || mem_err !== 1'b0) begin
            bad++;
            $display("FAIL reset: ctl=%b fwd=%b%b err=%b, want ctl=%b fwd=0000 err=0",
                     ctl(), fwd_a, fwd_b, mem_err, NORM);
        end
        @(negedge clk); clr(); rst_n = 1'b1; #1;
        total++;
        if (ctl() !== NORM || mem_err !== 1'b0) begin
            bad++; $display("FAIL reset_release: ctl=%b err=%b, want %b 0", ctl(), mem_err, NORM);
        end
    endtask

    task automatic test_forward();
        logic       ex_we [7];
        logic [4:0] ex_rd [7];
        logic       wb_we [7];
        logic [4:0] wb_rd [7];
        logic [4:0] rs1   [7];
        logic [4:0] rs2   [7];
        logic [3:0] exp_f [7];
        ex_we = '{1, 1, 0, 1, 1, 1, 1};
        ex_rd = '{5, 0, 5, 3, 0, 9, 9};
        wb_we = '{1, 1, 1, 1, 1, 0, 1};
        wb_rd = '{5, 5, 5, 4, 0, 9, 9};
        rs1   = '{5, 5, 5, 4, 0, 9, 8};
        rs2   = '{0, 0, 5, 3, 0, 9, 8};
        exp_f = '{4'b1000, 4'b0100, 4'b0101, 4'b0110, 4'b0000, 4'b1010, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            clr();
            exmem.RegWrite = ex_we[i]; exmem.rd = ex_rd[i];
            memwb.RegWrite = wb_we[i]; memwb.rd = wb_rd[i];
            idex.RS_One = rs1[i]; idex.RS_Two = rs2[i];
            #1;
            total++;
            if ({fwd_a, fwd_b} !== exp_f[i] || ctl() !== NORM) begin
                bad++;
                $display("FAIL fwd[%0d]: fwd_a/b=%b ctl=%b, want %b ctl=%b",
                         i, {fwd_a, fwd_b}, ctl(), exp_f[i], NORM);
            end
        end
    endtask

    task automatic test_load_use();
        logic [31:0] instr [5];
        logic [4:0]  ld_rd [5];
        logic [6:0]  exp_c [5];
        instr[0] = {7'b0, 5'd2, 5'd7, 3'b000, 5'd1, 7'b0110011};  // add x1,x7,x2
        instr[1] = {12'h000, 5'd7, 3'b000, 5'd7, 7'b0110111};      // lui x7 (imm bits alias rs1=7)
        instr[2] = {7'b0, 5'd7, 5'd1, 3'b010, 5'd0, 7'b0100011};   // sw x7,0(x1)
        instr[3] = {12'h007, 5'd0, 3'b000, 5'd1, 7'b0010011};      // addi x1,x0,7 (imm aliases rs2=7)
        instr[4] = {7'b0, 5'd0, 5'd0, 3'b000, 5'd1, 7'b0110011};   // add x1,x0,x0 vs load to x0
        ld_rd = '{7, 7, 7, 7, 0};
        exp_c = '{STALL, NORM, STALL, NORM, NORM};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clr();
            idex.MemRead = 1'b1; idex.RegWrite = 1'b1; idex.rd = ld_rd[i];
            ifid.Curr_Instr = instr[i];
            #1;
            total++;
            if (ctl() !== exp_c[i]) begin
                bad++; $display("FAIL load_use[%0d]: ctl=%b want %b", i, ctl(), exp_c[i]);
            end
            // next cycle idex holds the bubble
            @(negedge clk);
            idex = '0;
            #1;
            total++;
            if (ctl() !== NORM) begin
                bad++; $display("FAIL load_use_after[%0d]: ctl=%b want %b", i, ctl(), NORM);
            end
        end
    endtask

    task automatic test_redirect();
        // {Branch, br_taken, JalSel, JalrSel, load-use}
        logic [4:0] vec   [6];
        logic [6:0] exp_c [6];
        vec   = '{5'b00100, 5'b00101, 5'b11000, 5'b01000, 5'b10000, 5'b00010};
        exp_c = '{FLUSH, FLUSH, FLUSH, NORM, NORM, FLUSH};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clr();
            idex.Branch = vec[i][4]; br_taken = vec[i][3];
            idex.JalSel = vec[i][2]; idex.JalrSel = vec[i][1];
            if (vec[i][0]) begin
                idex.MemRead = 1'b1; idex.rd = 5'd7;
                ifid.Curr_Instr = {7'b0, 5'd2, 5'd7, 3'b000, 5'd1, 7'b0110011};
            end
            #1;
            total++;
            if (ctl() !== exp_c[i]) begin
                bad++; $display("FAIL redirect[%0d]: ctl=%b want %b", i, ctl(), exp_c[i]);
            end
            @(negedge clk);
            clr();
            #1;
            total++;
            if (ctl() !== NORM) begin
                bad++; $display("FAIL redirect_after[%0d]: ctl=%b want %b", i, ctl(), NORM);
            end
        end
    endtask

    task automatic test_mem_wait();
        // 3 not-ready cycles with a jump held in ID/EX
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clr();
            exmem.MemRead = 1'b1; idex.JalSel = 1'b1;
            dmem_ready = (i == 3);
            #1;
            total++;
            if (ctl() !== ((i == 3) ? FLUSH : FREEZE) || mem_err !== 1'b0) begin
                bad++;
                $display("FAIL mem_wait[%0d]: ctl=%b err=%b want %b 0",
                         i, ctl(), mem_err, (i == 3) ? FLUSH : FREEZE);
            end
        end
        @(negedge clk); clr(); #1;
        total++;
        if (ctl() !== NORM || mem_err !== 1'b0) begin
            bad++; $display("FAIL mem_wait_release: ctl=%b err=%b want %b 0", ctl(), mem_err, NORM);
        end
        // store: one wait cycle, then ready
        @(negedge clk); exmem.MemWrite = 1'b1; dmem_ready = 1'b0; #1;
        total++;
        if (ctl() !== FREEZE) begin
            bad++; $display("FAIL store_wait: ctl=%b want %b", ctl(), FREEZE);
        end
        @(negedge clk); dmem_ready = 1'b1; #1;
        total++;
        if (ctl() !== NORM) begin
            bad++; $display("FAIL store_ready: ctl=%b want %b", ctl(), NORM);
        end
        @(negedge clk); clr(); exmem.MemRead = 1'b1; #1;
        total++;
        if (ctl() !== NORM) begin
            bad++; $display("FAIL ready_first: ctl=%b want %b", ctl(), NORM);
        end
        @(negedge clk); clr();
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clr();
            exmem.MemRead = (i < 5);
            dmem_ready = (i == 5);
            #1;
            total++;
            if (ctl() !== FREEZE || mem_err !== (i >= 4)) begin
                bad++;
                $display("FAIL timeout[%0d]: ctl=%b err=%b want %b %b", i, ctl(), mem_err, FREEZE, i >= 4);
            end
        end
        @(negedge clk); rst_n = 1'b0; #1;
        total++;
        if (ctl() !== NORM || mem_err !== 1'b0) begin
            bad++; $display("FAIL timeout_rst: ctl=%b err=%b want %b 0", ctl(), mem_err, NORM);
        end
        @(negedge clk); rst_n = 1'b1;
        // reset mid-wait aborts immediately and restarts the count
        @(negedge clk); exmem.MemRead = 1'b1; dmem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b0; #1;
        total++;
        if (ctl() !== NORM || mem_err !== 1'b0) begin
            bad++; $display("FAIL midwait_rst: ctl=%b err=%b want %b 0", ctl(), mem_err, NORM);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++;
            if (ctl() !== FREEZE || mem_err !== (i == 4)) begin
                bad++;
                $display("FAIL rewait[%0d]: ctl=%b err=%b want %b %b", i, ctl(), mem_err, FREEZE, i == 4);
            end
        end
        @(negedge clk); clr(); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_counters();
        @(negedge clk); clr(); #1;
        total++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            bad++; $display("FAIL cnt_reset: stall=%0d flush=%0d want 0 0", stall_cycles, flush_count);
        end
        idex.MemRead = 1'b1; idex.rd = 5'd7;
        ifid.Curr_Instr = {7'b0, 5'd2, 5'd7, 3'b000, 5'd1, 7'b0110011};
        @(negedge clk); clr(); idex.JalSel = 1'b1;
        @(negedge clk); clr(); #1;
        total++;
        if (stall_cycles !== 32'd1 || flush_count !== 32'd1) begin
            bad++; $display("FAIL cnt: stall=%0d flush=%0d want 1 1", stall_cycles, flush_count);
        end
    endtask
`endif

    initial begin
        clr();
        rst_n = 1'b0;
        test_reset();
        test_forward();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_timeout();
`ifdef HAZARD_PERF_CNT_EN
        test_counters();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
